// File: rtl/alu_result_buffer_pkg.sv
// Shared ALU constants: flag bit positions within the N/Z/V/C nibble and the
// result buffer depth.
package alu_result_buffer_pkg;

   localparam int unsigned FLAG_N    = 3;
   localparam int unsigned FLAG_Z    = 2;
   localparam int unsigned FLAG_V    = 1;
   localparam int unsigned FLAG_C    = 0;

   localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/alu_result_buffer.sv
// Two-entry in-order skid buffer for ALU {result, flags} pairs, with sticky
// overflow/carry accumulation and a registered (lookahead-free) in_ready.
module alu_result_buffer
   import alu_result_buffer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_result,
   input  logic [3:0]   in_flags_n_z_v_c,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [3:0]   out_flags_n_z_v_c,
   output logic [1:0]   sticky_v_c,
   input  logic         sticky_clr,
   output logic [1:0]   count
);

   localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

   logic [1:0]   count_q, count_d;
   logic [N-1:0] head_result_q, head_result_d;
   logic [N-1:0] tail_result_q, tail_result_d;
   logic [3:0]   head_flags_q, head_flags_d;
   logic [3:0]   tail_flags_q, tail_flags_d;
   logic [1:0]   sticky_q, sticky_d;
   logic         in_ready_q;
   logic         push, pop;
   logic [1:0]   pushed_v_c;

   assign push       = in_valid && in_ready_q;
   assign pop        = (count_q != 2'd0) && out_ready;
   assign pushed_v_c = {in_flags_n_z_v_c[FLAG_V], in_flags_n_z_v_c[FLAG_C]};

   // The head register drives the outputs directly; the tail only holds the
   // second entry and shifts into the head when the head is popped.
   always_comb begin
      count_d       = count_q;
      head_result_d = head_result_q;
      head_flags_d  = head_flags_q;
      tail_result_d = tail_result_q;
      tail_flags_d  = tail_flags_q;
      unique case ({push, pop})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) begin
               head_result_d = in_result;
               head_flags_d  = in_flags_n_z_v_c;
            end else begin
               tail_result_d = in_result;
               tail_flags_d  = in_flags_n_z_v_c;
            end
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            if (count_q == FULL_COUNT) begin
               head_result_d = tail_result_q;
               head_flags_d  = tail_flags_q;
            end
         end
         2'b11: begin
            // Only reachable at count 1: the new entry replaces the popped head.
            head_result_d = in_result;
            head_flags_d  = in_flags_n_z_v_c;
         end
         default: begin
         end
      endcase
   end

   // A clear coinciding with a push keeps only the pushed bits.
   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr) begin
         sticky_d = push ? pushed_v_c : 2'b00;
      end else if (push) begin
         sticky_d = sticky_q | pushed_v_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q       <= 2'd0;
         head_result_q <= '0;
         head_flags_q  <= 4'd0;
         tail_result_q <= '0;
         tail_flags_q  <= 4'd0;
         sticky_q      <= 2'b00;
         in_ready_q    <= 1'b0;
      end else begin
         count_q       <= count_d;
         head_result_q <= head_result_d;
         head_flags_q  <= head_flags_d;
         tail_result_q <= tail_result_d;
         tail_flags_q  <= tail_flags_d;
         sticky_q      <= sticky_d;
         in_ready_q    <= (count_d != FULL_COUNT);
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = (count_q != 2'd0);
   assign out_result        = head_result_q;
   assign out_flags_n_z_v_c = head_flags_q;
   assign sticky_v_c        = sticky_q;
   assign count             = count_q;

endmodule
